// File: rtl/reorder_buffer_p.sv
// Purpose : in-order commit reorder buffer with two write-back channels and two operand-query lanes.
// Latency : commit outputs registered, valid the cycle after the head entry is ready; queries are combinational.
// Backpres: allocation refused while full; rdy low freezes all state and outputs.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), flush_in (external flush)
//   alloc_*  : new entry written at tail; alloc_tag/full/count report queue state
//   q_tag    : two query lanes (lane 0 low slice) -> q_value/q_ready, with write-back bypass
//   wb0_*    : ALU write-back (REG value or BRANCH jump/target); wb1_* : LSB write-back (any type)
//   commit_* : one-cycle pulse per retired entry; mispredict/redirect_pc on a wrong branch guess
module reorder_buffer_p #(
  parameter  int DEPTH = 16,
  parameter  int XLEN  = 32,
  localparam int IDW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush_in,
  input  logic              alloc_valid,
  input  logic [1:0]        alloc_type,
  input  logic [4:0]        alloc_rd,
  input  logic [XLEN-1:0]   alloc_pc,
  input  logic              alloc_pred,
  input  logic              alloc_ready,
  input  logic [XLEN-1:0]   alloc_value,
  output logic [IDW-1:0]    alloc_tag,
  output logic              full,
  output logic [IDW:0]      count,
  input  logic [2*IDW-1:0]  q_tag,
  output logic [2*XLEN-1:0] q_value,
  output logic [1:0]        q_ready,
  input  logic              wb0_valid,
  input  logic [IDW-1:0]    wb0_tag,
  input  logic [XLEN-1:0]   wb0_value,
  input  logic              wb0_jump,
  input  logic [XLEN-1:0]   wb0_target,
  input  logic              wb1_valid,
  input  logic [IDW-1:0]    wb1_tag,
  input  logic [XLEN-1:0]   wb1_value,
  output logic              commit_valid,
  output logic [1:0]        commit_type,
  output logic [IDW-1:0]    commit_tag,
  output logic [4:0]        commit_rd,
  output logic [XLEN-1:0]   commit_value,
  output logic [XLEN-1:0]   commit_pc,
  output logic              commit_jump,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc
);

  localparam logic [1:0]   T_STORE  = 2'b01;
  localparam logic [1:0]   T_BRANCH = 2'b10;
  localparam logic [IDW:0] DEPTH_C  = (IDW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0]      typ;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            pred;
    logic            jump;
    logic [XLEN-1:0] value;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] occ;      // entry holds a live instruction
  logic [DEPTH-1:0] rdy_bit;  // entry result available
  logic [IDW-1:0]   head;
  logic [IDW-1:0]   tail;

  logic do_alloc;
  logic do_commit;
  logic commit_mis;
  logic wb0_hit;
  logic wb1_hit;

  assign full      = (count == DEPTH_C);
  assign alloc_tag = tail;
  assign do_alloc  = alloc_valid && !full;
  assign do_commit = (count != '0) && occ[head] && rdy_bit[head];
  assign commit_mis = do_commit && (ent[head].typ == T_BRANCH) &&
                      (ent[head].pred != ent[head].jump);

  // wb1 wins a same-tag collision, so wb0 is dropped entirely in that case
  // (including its jump bit). Stores never take ALU results.
  assign wb1_hit = wb1_valid && occ[wb1_tag];
  assign wb0_hit = wb0_valid && occ[wb0_tag] && (ent[wb0_tag].typ != T_STORE) &&
                   !(wb1_hit && (wb1_tag == wb0_tag));

  // Operand query with same-cycle write-back bypass.
  always_comb begin
    q_value = '0;
    q_ready = '0;
    for (int i = 0; i < 2; i++) begin
      if (wb1_hit && (wb1_tag == q_tag[i*IDW +: IDW])) begin
        q_value[i*XLEN +: XLEN] = wb1_value;
        q_ready[i]              = 1'b1;
      end else if (wb0_hit && (wb0_tag == q_tag[i*IDW +: IDW])) begin
        q_value[i*XLEN +: XLEN] = (ent[wb0_tag].typ == T_BRANCH) ? wb0_target : wb0_value;
        q_ready[i]              = 1'b1;
      end else begin
        q_value[i*XLEN +: XLEN] = ent[q_tag[i*IDW +: IDW]].value;
        q_ready[i]              = rdy_bit[q_tag[i*IDW +: IDW]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      occ          <= '0;
      rdy_bit      <= '0;
      commit_valid <= 1'b0;
      commit_type  <= '0;
      commit_tag   <= '0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_pc    <= '0;
      commit_jump  <= 1'b0;
      mispredict   <= 1'b0;
      redirect_pc  <= '0;
    end else if (rdy) begin
      commit_valid <= 1'b0;
      mispredict   <= 1'b0;

      if (do_commit && !flush_in) begin
        commit_valid <= 1'b1;
        commit_type  <= ent[head].typ;
        commit_tag   <= head;
        commit_rd    <= ent[head].rd;
        commit_value <= ent[head].value;
        commit_pc    <= ent[head].pc;
        commit_jump  <= ent[head].jump;
      end

      if (flush_in || commit_mis) begin
        // Whole queue discarded; same-cycle allocation and write-backs are lost.
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        occ     <= '0;
        rdy_bit <= '0;
        if (!flush_in) begin
          mispredict  <= 1'b1;
          redirect_pc <= ent[head].value;
        end
      end else begin
        if (wb0_hit) begin
          rdy_bit[wb0_tag] <= 1'b1;
          if (ent[wb0_tag].typ == T_BRANCH) begin
            ent[wb0_tag].jump  <= wb0_jump;
            ent[wb0_tag].value <= wb0_target;
          end else begin
            ent[wb0_tag].value <= wb0_value;
          end
        end
        if (wb1_hit) begin
          rdy_bit[wb1_tag]   <= 1'b1;
          ent[wb1_tag].value <= wb1_value;
        end

        // Allocation targets the unoccupied tail, so it never collides with
        // a write-back (which requires an occupied tag) or the committing head.
        if (do_alloc) begin
          ent[tail].typ   <= alloc_type;
          ent[tail].rd    <= alloc_rd;
          ent[tail].pc    <= alloc_pc;
          ent[tail].pred  <= alloc_pred;
          ent[tail].jump  <= 1'b0;
          ent[tail].value <= alloc_value;
          rdy_bit[tail]   <= alloc_ready;
          occ[tail]       <= 1'b1;
          tail            <= tail + 1'b1;
        end

        if (do_commit) begin
          occ[head] <= 1'b0;
          head      <= head + 1'b1;
        end

        if (do_alloc && !do_commit) begin
          count <= count + 1'b1;
        end else if (!do_alloc && do_commit) begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_p.sv
module tb_reorder_buffer_p;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int IDW   = 2;
  localparam logic [1:0] T_REG    = 2'b00;
  localparam logic [1:0] T_BRANCH = 2'b10;

  logic              clk;
  logic              rst;
  logic              rdy;
  logic              flush_in;
  logic              alloc_valid;
  logic [1:0]        alloc_type;
  logic [4:0]        alloc_rd;
  logic [XLEN-1:0]   alloc_pc;
  logic              alloc_pred;
  logic              alloc_ready;
  logic [XLEN-1:0]   alloc_value;
  logic [IDW-1:0]    alloc_tag;
  logic              full;
  logic [IDW:0]      count;
  logic [2*IDW-1:0]  q_tag;
  logic [2*XLEN-1:0] q_value;
  logic [1:0]        q_ready;
  logic              wb0_valid;
  logic [IDW-1:0]    wb0_tag;
  logic [XLEN-1:0]   wb0_value;
  logic              wb0_jump;
  logic [XLEN-1:0]   wb0_target;
  logic              wb1_valid;
  logic [IDW-1:0]    wb1_tag;
  logic [XLEN-1:0]   wb1_value;
  logic              commit_valid;
  logic [1:0]        commit_type;
  logic [IDW-1:0]    commit_tag;
  logic [4:0]        commit_rd;
  logic [XLEN-1:0]   commit_value;
  logic [XLEN-1:0]   commit_pc;
  logic              commit_jump;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;

  reorder_buffer_p #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_in(flush_in),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_pred(alloc_pred), .alloc_ready(alloc_ready),
    .alloc_value(alloc_value), .alloc_tag(alloc_tag), .full(full), .count(count),
    .q_tag(q_tag), .q_value(q_value), .q_ready(q_ready),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value),
    .wb0_jump(wb0_jump), .wb0_target(wb0_target),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value),
    .commit_valid(commit_valid), .commit_type(commit_type), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_pc(commit_pc),
    .commit_jump(commit_jump), .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [IDW-1:0]  tag;
    logic [1:0]      typ;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] value;
    logic            jump;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; any commit pulse is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (commit_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_commit", {62'd0, commit_tag}, 64'hFF);
      end else begin
        e = sb_q.pop_front();
        chk("commit_tag",   {62'd0, commit_tag}, {62'd0, e.tag});
        chk("commit_type",  {62'd0, commit_type}, {62'd0, e.typ});
        chk("commit_rd",    {59'd0, commit_rd}, {59'd0, e.rd});
        chk("commit_pc",    {32'd0, commit_pc}, {32'd0, e.pc});
        chk("commit_value", {32'd0, commit_value}, {32'd0, e.value});
        chk("commit_jump",  {63'd0, commit_jump}, {63'd0, e.jump});
      end
    end
  endtask

  task automatic wb_model(input logic [IDW-1:0] t, input logic [XLEN-1:0] v, input logic j);
    foreach (sb_q[i]) begin
      if (sb_q[i].tag == t) begin
        sb_q[i].value = v;
        sb_q[i].jump  = j;
      end
    end
  endtask

  task automatic drive_alloc(input logic [1:0] typ, input logic [4:0] rd, input logic [XLEN-1:0] pc,
                             input logic pred, input logic rv, input logic [XLEN-1:0] val);
    alloc_valid = 1'b1;
    alloc_type  = typ;
    alloc_rd    = rd;
    alloc_pc    = pc;
    alloc_pred  = pred;
    alloc_ready = rv;
    alloc_value = val;
  endtask

  task automatic do_alloc(input logic [1:0] typ, input logic [4:0] rd, input logic [XLEN-1:0] pc,
                          input logic pred, input logic rv, input logic [XLEN-1:0] val,
                          input logic [IDW-1:0] exp_tag, input logic push);
    exp_t e;
    drive_alloc(typ, rd, pc, pred, rv, val);
    chk("alloc_tag", {62'd0, alloc_tag}, {62'd0, exp_tag});
    if (push) begin
      e.tag = exp_tag; e.typ = typ; e.rd = rd; e.pc = pc; e.value = val; e.jump = 1'b0;
      sb_q.push_back(e);
    end
    tick();
    alloc_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; flush_in = 1'b0;
    alloc_valid = 1'b0; alloc_type = '0; alloc_rd = '0; alloc_pc = '0;
    alloc_pred = 1'b0; alloc_ready = 1'b0; alloc_value = '0;
    q_tag = '0;
    wb0_valid = 1'b0; wb0_tag = '0; wb0_value = '0; wb0_jump = 1'b0; wb0_target = '0;
    wb1_valid = 1'b0; wb1_tag = '0; wb1_value = '0;

    // Reset applies even with rdy low.
    tick(); tick();
    chk("rst_count", {59'd0, count}, 64'd0);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_alloc_tag", {62'd0, alloc_tag}, 64'd0);
    chk("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("rst_mispredict", {63'd0, mispredict}, 64'd0);
    rst = 1'b0; rdy = 1'b1;
    tick();

    // Fill, reject when full, commit tag 0, wrap allocation to tag 0.
    for (int i = 0; i < 4; i++)
      do_alloc(T_REG, 5'(i + 1), 32'h100 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 2'(i), 1'b1);
    chk("fill_full", {63'd0, full}, 64'd1);
    chk("fill_count", {59'd0, count}, 64'd4);
    drive_alloc(T_REG, 5'd20, 32'h900, 1'b0, 1'b1, 32'hEE);
    tick();
    alloc_valid = 1'b0;
    chk("reject_count", {59'd0, count}, 64'd4);
    chk("reject_full", {63'd0, full}, 64'd1);
    wb1_valid = 1'b1; wb1_tag = 2'd0; wb1_value = 32'h11;
    wb_model(2'd0, 32'h11, 1'b0);
    tick();
    wb1_valid = 1'b0;
    chk("commit_latency", {63'd0, commit_valid}, 64'd0);
    tick();
    chk("first_commit_valid", {63'd0, commit_valid}, 64'd1);
    chk("first_commit_tag", {62'd0, commit_tag}, 64'd0);
    chk("after_commit_count", {59'd0, count}, 64'd3);
    do_alloc(T_REG, 5'd9, 32'h300, 1'b0, 1'b1, 32'hAA, 2'd0, 1'b1);
    chk("commit_pulse", {63'd0, commit_valid}, 64'd0);
    chk("wrap_count", {59'd0, count}, 64'd4);

    // Out-of-order write-back, in-order commit.
    wb0_valid = 1'b1; wb0_tag = 2'd2; wb0_value = 32'd9;
    wb_model(2'd2, 32'd9, 1'b0);
    tick();
    wb0_valid = 1'b0;
    chk("hold_tag2_a", {63'd0, commit_valid}, 64'd0);
    tick();
    chk("hold_tag2_b", {63'd0, commit_valid}, 64'd0);
    wb0_valid = 1'b1; wb0_tag = 2'd1; wb0_value = 32'd7;
    wb_model(2'd1, 32'd7, 1'b0);
    tick();
    wb0_valid = 1'b0;
    tick();
    chk("order_first", {62'd0, commit_tag}, 64'd1);
    tick();
    chk("order_second", {62'd0, commit_tag}, 64'd2);
    chk("order_count", {59'd0, count}, 64'd2);

    // Allocate and commit together at count 2.
    wb1_valid = 1'b1; wb1_tag = 2'd3; wb1_value = 32'h33;
    wb_model(2'd3, 32'h33, 1'b0);
    tick();
    wb1_valid = 1'b0;
    do_alloc(T_REG, 5'd10, 32'h400, 1'b0, 1'b0, 32'h0, 2'd1, 1'b1);
    chk("both_commit_tag", {62'd0, commit_tag}, 64'd3);
    chk("both_count", {59'd0, count}, 64'd2);
    tick();
    chk("drain_count", {59'd0, count}, 64'd1);

    // Query bypass: wb0 alone, then wb1 overriding on the same tag.
    do_alloc(T_REG, 5'd11, 32'h404, 1'b0, 1'b0, 32'h0, 2'd2, 1'b1);
    do_alloc(T_REG, 5'd12, 32'h408, 1'b0, 1'b0, 32'h0, 2'd3, 1'b1);
    q_tag = {2'd1, 2'd3};
    wb0_valid = 1'b1; wb0_tag = 2'd3; wb0_value = 32'h55;
    #1;
    chk("byp_wb0_ready", {63'd0, q_ready[0]}, 64'd1);
    chk("byp_wb0_value", {32'd0, q_value[31:0]}, 64'h55);
    chk("byp_lane1_ready", {63'd0, q_ready[1]}, 64'd0);
    wb1_valid = 1'b1; wb1_tag = 2'd3; wb1_value = 32'h66;
    #1;
    chk("byp_wb1_value", {32'd0, q_value[31:0]}, 64'h66);
    wb_model(2'd3, 32'h66, 1'b0);
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    #1;
    chk("stored_wb1_prio", {32'd0, q_value[31:0]}, 64'h66);
    chk("stored_ready", {63'd0, q_ready[0]}, 64'd1);

    // rdy low with stimulus present: nothing moves.
    rdy = 1'b0;
    drive_alloc(T_REG, 5'd13, 32'h40C, 1'b0, 1'b1, 32'h44);
    wb0_valid = 1'b1; wb0_tag = 2'd1; wb0_value = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_low_count", {59'd0, count}, 64'd3);
      chk("rdy_low_tail", {62'd0, alloc_tag}, 64'd0);
      chk("rdy_low_commit", {63'd0, commit_valid}, 64'd0);
    end
    alloc_valid = 1'b0; wb0_valid = 1'b0; rdy = 1'b1;
    #1;
    chk("rdy_low_no_wb", {63'd0, q_ready[1]}, 64'd0);

    // Drain: two channels writing different tags in one cycle.
    wb0_valid = 1'b1; wb0_tag = 2'd1; wb0_value = 32'h71;
    wb1_valid = 1'b1; wb1_tag = 2'd2; wb1_value = 32'h72;
    wb_model(2'd1, 32'h71, 1'b0);
    wb_model(2'd2, 32'h72, 1'b0);
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    tick(); tick(); tick();
    chk("drained_last_tag", {62'd0, commit_tag}, 64'd3);
    chk("drained_count", {59'd0, count}, 64'd0);

    // Branch mispredict clears the queue, discarding a simultaneous allocation.
    do_alloc(T_BRANCH, 5'd0, 32'h200, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    do_alloc(T_REG, 5'd14, 32'h204, 1'b0, 1'b1, 32'hBB, 2'd1, 1'b0);
    chk("mis_pre_count", {59'd0, count}, 64'd2);
    wb0_valid = 1'b1; wb0_tag = 2'd0; wb0_jump = 1'b1; wb0_target = 32'h1000; wb0_value = 32'hDEAD;
    wb_model(2'd0, 32'h1000, 1'b1);
    tick();
    wb0_valid = 1'b0; wb0_jump = 1'b0;
    drive_alloc(T_REG, 5'd15, 32'h208, 1'b0, 1'b1, 32'hCC);
    tick();
    alloc_valid = 1'b0;
    chk("mis_flag", {63'd0, mispredict}, 64'd1);
    chk("mis_redirect", {32'd0, redirect_pc}, 64'h1000);
    chk("mis_count", {59'd0, count}, 64'd0);
    chk("mis_alloc_tag", {62'd0, alloc_tag}, 64'd0);
    tick();
    chk("mis_pulse", {63'd0, mispredict}, 64'd0);
    chk("mis_no_commit", {63'd0, commit_valid}, 64'd0);
    chk("mis_count_after", {59'd0, count}, 64'd0);

    // External flush beats a simultaneous allocation.
    do_alloc(T_REG, 5'd5, 32'h500, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    chk("flush_pre_count", {59'd0, count}, 64'd1);
    flush_in = 1'b1;
    drive_alloc(T_REG, 5'd6, 32'h504, 1'b0, 1'b1, 32'hCC);
    sb_q.delete();
    tick();
    flush_in = 1'b0; alloc_valid = 1'b0;
    chk("flush_count", {59'd0, count}, 64'd0);
    chk("flush_alloc_tag", {62'd0, alloc_tag}, 64'd0);
    chk("flush_no_mis", {63'd0, mispredict}, 64'd0);
    tick();
    chk("flush_no_commit", {63'd0, commit_valid}, 64'd0);
    chk("flush_count_after", {59'd0, count}, 64'd0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reorder_buffer_p.md
REORDER_BUFFER_P -- requirements
Module: reorder_buffer_p

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of two, at least 4); IDW = log2(DEPTH) is the tag width.
REQ-002 SHALL have parameter XLEN, default 32, data and PC width.
REQ-003 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-005 SHALL have port rdy, input, 1, global enable; when low, all state holds.
REQ-006 SHALL have port flush_in, input, 1, external flush request.
REQ-007 SHALL have ports alloc_valid (in, 1), alloc_type (in, 2; 00 REG, 01 STORE, 10 BRANCH), alloc_rd (in, 5), alloc_pc (in, XLEN), alloc_pred (in, 1, predicted taken), alloc_ready (in, 1), alloc_value (in, XLEN).
REQ-008 SHALL have ports alloc_tag (out, IDW, tag of the next entry to be allocated), full (out, 1), count (out, IDW+1, occupied entries).
REQ-009 SHALL have ports q_tag (in, 2*IDW), q_value (out, 2*XLEN), q_ready (out, 2); these form two operand-query lanes, lane 0 in the low slice.
REQ-010 SHALL have ports wb0_valid (in, 1), wb0_tag (in, IDW), wb0_value (in, XLEN), wb0_jump (in, 1), wb0_target (in, XLEN); this is the ALU channel.
REQ-011 SHALL have ports wb1_valid (in, 1), wb1_tag (in, IDW), wb1_value (in, XLEN); this is the LSB channel.
REQ-012 SHALL have ports commit_valid (out, 1), commit_type (out, 2), commit_tag (out, IDW), commit_rd (out, 5), commit_value (out, XLEN), commit_pc (out, XLEN), commit_jump (out, 1).
REQ-013 SHALL have ports mispredict (out, 1) and redirect_pc (out, XLEN).

Function
REQ-014 SHALL keep a circular queue of DEPTH entries with head (oldest) and tail pointers; both wrap modulo DEPTH. Occupancy is tracked by count, never inferred from head==tail.
REQ-015 SHALL drive full = (count == DEPTH) and alloc_tag = tail combinationally.
REQ-016 SHALL accept an allocation when rdy && alloc_valid && !full. On acceptance the entry is written with type, rd, pc, pred, ready and value, and tail increments. Allocation is blocked while full even if a commit occurs in the same cycle.
REQ-017 SHALL apply wb0 on rdy && wb0_valid when the entry is occupied. For REG: ready=1, value=wb0_value. For BRANCH: ready=1, jump=wb0_jump, value=wb0_target. For STORE: ignored.
REQ-018 SHALL apply wb1 on rdy && wb1_valid when the entry is occupied, for any type: ready=1, value=wb1_value. A write-back to an unoccupied tag SHALL be ignored.
REQ-019 SHALL give wb1 priority over wb0 when both write the same tag in the same cycle.
REQ-020 SHALL answer each query lane combinationally from the addressed entry, with a bypass: if wb1 (else wb0, REG/BRANCH only) targets that tag this cycle, return that value with ready=1.
REQ-021 SHALL commit at most one entry per cycle. Commit occurs when rdy && count>0 && ready[head]; head increments; outputs are registered and valid on the next cycle as a 1-cycle pulse.
REQ-022 SHALL adjust count as +1 on allocation only, -1 on commit only, and leave it unchanged when both occur.
REQ-023 SHALL, when a committed BRANCH has pred != jump, register mispredict=1 and redirect_pc=value. On that same edge all entries SHALL be invalidated, head=tail=0, count=0, and any simultaneous allocation or write-back SHALL be discarded.
REQ-024 SHALL, on flush_in (with rdy), apply the same clearing as REQ-023 but without asserting mispredict. flush_in SHALL take priority over commit, allocation and write-back.
REQ-025 SHALL clear commit_valid and mispredict at every enabled edge with no new event. When rdy is low, all outputs SHALL hold.

Reset
REQ-026 SHALL, on rst (regardless of rdy), set head=tail=0, count=0, all ready bits=0, and all registered outputs to 0; full therefore reads 0 and alloc_tag reads 0.

Verification
REQ-027 SHALL be covered by this fill/wrap scenario: DEPTH=4; allocate 4 REG entries with alloc_ready=0 -> full=1, count=4, and a 5th allocation is rejected; write back tag 0 -> commit_tag=0 appears one cycle later; the next allocation receives tag 0 (wrap).
REQ-028 SHALL be covered by this in-order scenario: write back tag 2 before tag 1 (tags 1 and 2 with value 7 and 9) -> no commit of tag 2 until tag 1 commits; commits occur in order 1, 2.
REQ-029 SHALL be covered by this mispredict scenario: BRANCH entry with pred=0, wb0 jump=1, target=0x1000 -> mispredict=1, redirect_pc=0x1000 for one cycle; count=0 on the following cycle.
REQ-030 SHALL be covered by this bypass scenario: q_tag lane 0 = 3 while wb0 writes tag 3 with value 0x55 in the same cycle -> q_ready[0]=1, q_value low slice = 0x55. With wb1 writing 0x66 to tag 3 simultaneously -> 0x66.
REQ-031 SHALL be covered by these simultaneous/flush scenarios: allocate and commit in the same cycle at count=2 -> count stays 2; flush_in together with alloc_valid -> count=0 and no entry is allocated.
REQ-032 SHALL be covered by this rdy-low scenario: hold rdy=0 for 3 cycles with stimulus present -> no pointer, count or output change.
